// File: rtl/trdb_pkg.sv
// trdb_pkg: shared constants and FSM encoding for the trace qualification pipeline.
package trdb_pkg;

    localparam int RESYNC_LEN = 8;

    typedef enum logic [1:0] {
        OFF,
        WAIT_QUAL,
        ACTIVE,
        RESYNC
    } qual_state_e;

endpackage

// File: rtl/trdb_qual_pipe.sv
// trdb_qual_pipe: tracks this/last-cycle qualification of retired instructions
// and requests a periodic sync packet after resync_max_i counted instructions.
module trdb_qual_pipe
    import trdb_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  trace_enable_i,
    input  logic                  valid_i,
    input  logic                  nc_qualified_i,
    input  logic                  sync_emitted_i,
    input  logic [RESYNC_LEN-1:0] resync_max_i,
    output logic                  tc_qualified_o,
    output logic                  lc_qualified_o,
    output logic                  tc_first_qualified_o,
    output logic                  tc_last_qualified_o,
    output logic                  resync_o,
    output logic [RESYNC_LEN-1:0] resync_cnt_o
);

    qual_state_e           state, state_nxt;
    logic                  tc, lc;
    logic [RESYNC_LEN-1:0] cnt, cnt_nxt;
    logic                  count_en, terminal;

    assign count_en = valid_i && tc && state == ACTIVE;
    // Equality (not >=) so a period lowered below the count waits for a sync clear.
    assign terminal = count_en && resync_max_i != '0 && cnt == resync_max_i - RESYNC_LEN'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= OFF;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            OFF:       state_nxt = WAIT_QUAL;
            WAIT_QUAL: state_nxt = (valid_i && nc_qualified_i) ? ACTIVE : WAIT_QUAL;
            ACTIVE:    state_nxt = (terminal && !sync_emitted_i) ? RESYNC :
                                   (valid_i && !nc_qualified_i) ? WAIT_QUAL : ACTIVE;
            RESYNC:    state_nxt = sync_emitted_i ? ACTIVE : RESYNC;
            default:   state_nxt = OFF;
        endcase
        if (!trace_enable_i)
            state_nxt = OFF;
    end

    always_comb begin
        cnt_nxt = cnt;
        if (sync_emitted_i || (state == WAIT_QUAL && state_nxt == ACTIVE))
            cnt_nxt = '0;
        else if (count_en && cnt != '1)
            cnt_nxt = cnt + RESYNC_LEN'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tc  <= 1'b0;
            lc  <= 1'b0;
            cnt <= '0;
        end else if (!trace_enable_i) begin
            tc  <= 1'b0;
            lc  <= 1'b0;
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
            if (valid_i) begin
                lc <= tc;
                tc <= nc_qualified_i;
            end
        end
    end

    always_comb begin
        tc_qualified_o       = tc;
        lc_qualified_o       = lc;
        tc_first_qualified_o = trace_enable_i && tc && !lc;
        tc_last_qualified_o  = trace_enable_i && tc && !nc_qualified_i;
        resync_o             = state == RESYNC;
        resync_cnt_o         = cnt;
    end

endmodule
